// File: rtl/uart_prog_loader.sv
// UART program-download sequencer: parses A5/SEL/LEN/data/CHK frames from the
// receiver, writes little-endian words to IMem/DMem and holds the CPU until the checksum verifies.
module uart_prog_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_pg,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        cpu_hold,
    output logic        err
);
    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   MAX_LEN  = 16'd16384;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_HDR, S_SEL, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t        r_state, w_next;
    logic          r_start_d;
    logic          r_sel;
    logic [7:0]    r_acc;
    logic [7:0]    r_len_lo;
    logic [14:0]   r_rem;
    logic [1:0]    r_bcnt;
    logic [23:0]   r_asm;
    logic [13:0]   r_adr;
    logic [TW-1:0] r_tmo;

    logic          w_restart;
    logic          w_take;
    logic          w_timed;
    logic          w_tmo;
    logic [15:0]   w_len;

    // A restart edge wins over a coincident byte, so the byte is never taken.
    assign w_restart = start_pg & ~r_start_d;
    assign w_take    = rx_valid & ~w_restart;
    assign w_len     = {rx_data, r_len_lo};
    assign w_timed   = r_state inside {S_SEL, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
    assign w_tmo     = w_timed && (r_tmo == TMO_LAST);

    assign upg_done_o = (r_state == S_IDLE) || (r_state == S_DONE);
    assign cpu_hold   = ~upg_done_o;
    assign err        = (r_state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_restart) begin
            w_next = S_WAIT_HDR;
        end else begin
            case (r_state)
                S_WAIT_HDR: if (w_take && rx_data == 8'hA5) w_next = S_SEL;
                S_SEL:      if (w_take) w_next = S_LEN_LO; else if (w_tmo) w_next = S_ERR;
                S_LEN_LO:   if (w_take) w_next = S_LEN_HI; else if (w_tmo) w_next = S_ERR;
                S_LEN_HI: begin
                    if (w_take) begin
                        if (w_len > MAX_LEN)    w_next = S_ERR;
                        else if (w_len == 16'd0) w_next = S_CHK;
                        else                     w_next = S_DATA;
                    end else if (w_tmo) begin
                        w_next = S_ERR;
                    end
                end
                S_DATA: begin
                    if (w_take) begin
                        if (r_bcnt == 2'd3 && r_rem == 15'd1) w_next = S_CHK;
                    end else if (w_tmo) begin
                        w_next = S_ERR;
                    end
                end
                S_CHK: begin
                    if (w_take)     w_next = (rx_data == r_acc) ? S_DONE : S_ERR;
                    else if (w_tmo) w_next = S_ERR;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d <= 1'b0;
            r_sel     <= 1'b0;
            r_acc     <= '0;
            r_len_lo  <= '0;
            r_rem     <= '0;
            r_bcnt    <= '0;
            r_asm     <= '0;
            r_adr     <= '0;
            r_tmo     <= '0;
            upg_wen_o <= 1'b0;
            upg_adr_o <= '0;
            upg_dat_o <= '0;
        end else begin
            r_start_d <= start_pg;
            upg_wen_o <= 1'b0;
            if (w_restart) begin
                r_sel  <= 1'b0;
                r_acc  <= '0;
                r_rem  <= '0;
                r_bcnt <= '0;
                r_adr  <= '0;
                r_tmo  <= '0;
            end else begin
                if (w_timed) r_tmo <= r_tmo + 1'b1;
                if (w_take) begin
                    r_tmo <= '0;
                    case (r_state)
                        S_SEL: begin
                            r_sel <= rx_data[0];
                            r_acc <= rx_data;
                        end
                        S_LEN_LO: begin
                            r_len_lo <= rx_data;
                            r_acc    <= r_acc ^ rx_data;
                        end
                        S_LEN_HI: begin
                            r_rem <= w_len[14:0];
                            r_acc <= r_acc ^ rx_data;
                        end
                        S_DATA: begin
                            r_acc  <= r_acc ^ rx_data;
                            r_bcnt <= r_bcnt + 1'b1;
                            // Bytes enter at the top, so after three the first byte sits lowest.
                            if (r_bcnt == 2'd3) begin
                                upg_wen_o <= 1'b1;
                                upg_adr_o <= {r_sel, r_adr};
                                upg_dat_o <= {rx_data, r_asm};
                                r_adr     <= r_adr + 1'b1;
                                r_rem     <= r_rem - 1'b1;
                            end else begin
                                r_asm <= {rx_data, r_asm[23:8]};
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed and random frames compared
// against a frame-level reference model of expected writes and final status.
module tb_uart_prog_loader;
    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_pg;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        cpu_hold;
    logic        err;

    uart_prog_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_pg   (start_pg),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .cpu_hold   (cpu_hold),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] mon_adr[$];
    logic [31:0] mon_dat[$];
    always @(posedge clk) begin
        #1;
        if (upg_wen_o === 1'b1) begin
            mon_adr.push_back(upg_adr_o);
            mon_dat.push_back(upg_dat_o);
        end
    end

    logic [7:0]  frame[$];
    logic [14:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    int          exp_status;   // 0 = still in session, 1 = done, 2 = error

    // Reference: walk the byte list frame-by-frame using the framing rules.
    task automatic model_frame();
        int i;
        int unsigned len;
        logic [7:0] sel, chk;
        exp_adr.delete();
        exp_dat.delete();
        exp_status = 0;
        i = 0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        if (i + 3 >= frame.size()) return;
        sel = frame[i+1];
        len = {frame[i+3], frame[i+2]};
        chk = sel ^ frame[i+2] ^ frame[i+3];
        i += 4;
        if (len > 16384) begin
            exp_status = 2;
            return;
        end
        for (int unsigned k = 0; k < len; k++) begin
            if (i + 3 >= frame.size()) return;
            exp_adr.push_back({sel[0], 14'(k)});
            exp_dat.push_back({frame[i+3], frame[i+2], frame[i+1], frame[i]});
            chk ^= frame[i] ^ frame[i+1] ^ frame[i+2] ^ frame[i+3];
            i += 4;
        end
        if (i >= frame.size()) return;
        exp_status = (frame[i] == chk) ? 1 : 2;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_pg = 1'b1;
        @(negedge clk); start_pg = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic run_frame(input string name, input bit do_start, input int maxgap);
        logic [2:0] exp_st;
        model_frame();
        mon_adr.delete();
        mon_dat.delete();
        if (do_start) pulse_start();
        foreach (frame[i]) send_byte(frame[i], int'($urandom_range(0, maxgap)));
        exp_st = (exp_status == 0) ? 3'b100 : (exp_status == 1) ? 3'b010 : 3'b101;
        n_checks++;
        if ({cpu_hold, upg_done_o, err} !== exp_st) begin
            n_errors++;
            $display("FAIL %s status hold/done/err: got %b exp %b", name, {cpu_hold, upg_done_o, err}, exp_st);
        end
        n_checks++;
        if (mon_adr.size() != exp_adr.size()) begin
            n_errors++;
            $display("FAIL %s write count: got %0d exp %0d", name, mon_adr.size(), exp_adr.size());
        end else begin
            foreach (exp_adr[i]) begin
                n_checks++;
                if ({mon_adr[i], mon_dat[i]} !== {exp_adr[i], exp_dat[i]}) begin
                    n_errors++;
                    $display("FAIL %s write %0d: got adr %h dat %h exp adr %h dat %h",
                             name, i, mon_adr[i], mon_dat[i], exp_adr[i], exp_dat[i]);
                end
            end
        end
        if (exp_adr.size() > 0) begin
            n_checks++;
            if ({upg_adr_o, upg_dat_o} !== {exp_adr[$], exp_dat[$]}) begin
                n_errors++;
                $display("FAIL %s held bus: got adr %h dat %h exp adr %h dat %h",
                         name, upg_adr_o, upg_dat_o, exp_adr[$], exp_dat[$]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_pg = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({upg_wen_o, upg_adr_o, upg_dat_o} !== 48'h0) begin
            n_errors++;
            $display("FAIL reset bus: got wen %b adr %h dat %h exp all 0", upg_wen_o, upg_adr_o, upg_dat_o);
        end
        n_checks++;
        if ({cpu_hold, upg_done_o, err} !== 3'b010) begin
            n_errors++;
            $display("FAIL reset status hold/done/err: got %b exp 010", {cpu_hold, upg_done_o, err});
        end
    endtask

    // CHK values below are the XOR of SEL, both LEN bytes and every data byte.
    task automatic test_directed();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'hB3, 8'h00, 8'h10, 8'h00, 8'hB2};
        run_frame("imem_load", 1'b1, 2);
        frame = '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_frame("dmem_garbage", 1'b1, 2);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'hB3, 8'h00, 8'h10, 8'h00, 8'h00};
        run_frame("chk_bad", 1'b1, 0);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("len_zero", 1'b1, 1);
        frame = '{8'hA5, 8'h00, 8'h01, 8'h40};
        run_frame("len_over", 1'b1, 0);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h40, 8'h00};
        run_frame("len_max_trunc", 1'b1, 0);
    endtask

    task automatic test_random();
        logic [7:0]  b, sel, chk;
        logic [15:0] len;
        int          mode;
        for (int n = 0; n < 16; n++) begin
            frame.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                frame.push_back(b);
            end
            sel  = 8'($urandom);
            mode = int'($urandom_range(0, 7));
            len  = (mode == 0) ? 16'(16385 + $urandom_range(0, 200)) : 16'($urandom_range(0, 5));
            chk  = sel ^ len[7:0] ^ len[15:8];
            frame.push_back(8'hA5);
            frame.push_back(sel);
            frame.push_back(len[7:0]);
            frame.push_back(len[15:8]);
            if (mode != 0) begin
                for (int unsigned k = 0; k < 4 * len; k++) begin
                    b = 8'($urandom);
                    frame.push_back(b);
                    chk ^= b;
                end
                if (mode == 1) chk ^= 8'($urandom_range(1, 255));
                if (mode != 2) frame.push_back(chk);
            end
            run_frame($sformatf("rand%0d", n), 1'b1, (n % 2 == 0) ? 0 : 3);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] c;
        frame = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        run_frame("tmo_partial", 1'b1, 1);
        for (int k = 1; k <= int'(TMO); k++) begin
            @(negedge clk);
            if (k == int'(TMO) - 1) begin
                n_checks++;
                if (err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL tmo_early err: got %b exp 0 at %0d cycles", err, k);
                end
            end
            if (k == int'(TMO)) begin
                n_checks++;
                if ({cpu_hold, upg_done_o, err} !== 3'b101) begin
                    n_errors++;
                    $display("FAIL tmo_fire hold/done/err: got %b exp 101", {cpu_hold, upg_done_o, err});
                end
            end
        end
        pulse_start();
        n_checks++;
        if ({cpu_hold, upg_done_o, err} !== 3'b100) begin
            n_errors++;
            $display("FAIL tmo_restart hold/done/err: got %b exp 100", {cpu_hold, upg_done_o, err});
        end
        c = 8'h01 ^ 8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11;
        frame = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, c};
        run_frame("tmo_reload", 1'b1, 1);
    endtask

    task automatic test_reset_mid_data();
        mon_adr.delete();
        mon_dat.delete();
        pulse_start();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        // Reset lands on the word-completing byte, so its strobe must never appear.
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'hDD; rst = 1'b1;
        @(negedge clk); rx_valid = 1'b0; rst = 1'b0;
        n_checks++;
        if ({upg_wen_o, upg_adr_o, upg_dat_o, cpu_hold, upg_done_o, err} !== {48'h0, 3'b010}) begin
            n_errors++;
            $display("FAIL rst_mid outputs: got wen %b adr %h dat %h hold/done/err %b exp 0/0/0/010",
                     upg_wen_o, upg_adr_o, upg_dat_o, {cpu_hold, upg_done_o, err});
        end
        n_checks++;
        if (mon_adr.size() != 0) begin
            n_errors++;
            $display("FAIL rst_mid strobes: got %0d exp 0", mon_adr.size());
        end
    endtask

    task automatic test_restart_collision();
        logic [7:0] c;
        pulse_start();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        @(negedge clk); start_pg = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        @(negedge clk); rx_valid = 1'b0;
        n_checks++;
        if ({cpu_hold, upg_done_o, err} !== 3'b100) begin
            n_errors++;
            $display("FAIL collide status hold/done/err: got %b exp 100", {cpu_hold, upg_done_o, err});
        end
        // start_pg stays high for the whole frame; it must not retrigger.
        c = 8'h01 ^ 8'h01 ^ 8'h00 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
        frame = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, c};
        run_frame("collide_frame", 1'b0, 1);
        repeat (5) @(negedge clk);
        n_checks++;
        if ({cpu_hold, upg_done_o, err} !== 3'b010) begin
            n_errors++;
            $display("FAIL held_start status hold/done/err: got %b exp 010", {cpu_hold, upg_done_o, err});
        end
        start_pg = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_mid_data();
        test_restart_collision();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
